// File: rtl/demux2output16bit_stream.sv
// demux2output16bit_stream: 1-to-2 word demux with registered valid/ready outputs and delivery counters
module demux2output16bit_stream #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S,
  input  logic [WIDTH-1:0] A,
  input  logic             IVALID,
  output logic             IREADY,
  output logic [WIDTH-1:0] O0,
  output logic             O0VALID,
  input  logic             O0READY,
  output logic [WIDTH-1:0] O1,
  output logic             O1VALID,
  input  logic             O1READY,
  output logic [CNTW-1:0]  COUNT0,
  output logic [CNTW-1:0]  COUNT1
);
  logic cap0, cap1;
  assign IREADY = S ? (!O1VALID || O1READY) : (!O0VALID || O0READY);
  assign cap0 = IVALID && IREADY && !S;
  assign cap1 = IVALID && IREADY && S;
  // output 0 buffer: a capture refills it, otherwise a delivery empties it; data holds when not captured
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      O0      <= '0;
      O0VALID <= 1'b0;
      COUNT0  <= '0;
    end else begin
      if (cap0) O0 <= A;
      O0VALID <= cap0 || (O0VALID && !O0READY);
      if (O0VALID && O0READY) COUNT0 <= COUNT0 + CNTW'(1);
    end
  // output 1 buffer: same behaviour as output 0, driven by the other select value
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      O1      <= '0;
      O1VALID <= 1'b0;
      COUNT1  <= '0;
    end else begin
      if (cap1) O1 <= A;
      O1VALID <= cap1 || (O1VALID && !O1READY);
      if (O1VALID && O1READY) COUNT1 <= COUNT1 + CNTW'(1);
    end
endmodule

// File: tb/tb_demux2output16bit_stream.sv
// tb_demux2output16bit_stream: vector table, hand sequences and a delivery scoreboard for the demux
module tb_demux2output16bit_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0;
  logic [15:0] a = '0;
  logic        ivalid = 1'b0;
  logic        iready;
  logic [15:0] o0, o1;
  logic        o0valid, o1valid;
  logic        o0ready = 1'b0;
  logic        o1ready = 1'b0;
  logic [7:0]  count0, count1;
  int checks = 0;
  int errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic        iv, r0, r1, er, ev0, ev1;
    logic [7:0]  c0, c1;
  } vec_t;
  vec_t tbl[7];

  demux2output16bit_stream dut (
    .CLK(clk), .RST_N(rst_n), .S(s), .A(a), .IVALID(ivalid), .IREADY(iready),
    .O0(o0), .O0VALID(o0valid), .O0READY(o0ready),
    .O1(o1), .O1VALID(o1valid), .O1READY(o1ready),
    .COUNT0(count0), .COUNT1(count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ivalid = 1'b0;
    o0ready = 1'b0;
    o1ready = 1'b0;
    #20;
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    step();
  endtask

  // scoreboard: accepted words are queued per destination and checked in order on delivery
  always @(posedge clk)
    if (rst_n) begin
      if (o0valid && o0ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL o0_extra: got %0h expected none", o0);
        end else chk("o0_data", {16'h0, o0}, {16'h0, q0.pop_front()});
      end
      if (o1valid && o1ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL o1_extra: got %0h expected none", o1);
        end else chk("o1_data", {16'h0, o1}, {16'h0, q1.pop_front()});
      end
      if (ivalid && iready) begin
        if (s) q1.push_back(a);
        else q0.push_back(a);
      end
    end

  initial begin
    tbl[0] = '{1'b0, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
    tbl[1] = '{1'b0, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    tbl[2] = '{1'b1, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0};
    tbl[3] = '{1'b1, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 8'd1};
    tbl[4] = '{1'b0, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2};
    tbl[5] = '{1'b1, 16'h6666, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2};
    tbl[6] = '{1'b0, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2};

    #95;
    chk("rst_o0", {16'h0, o0}, 32'h0);
    chk("rst_o1", {16'h0, o1}, 32'h0);
    chk("rst_valids", {30'h0, o0valid, o1valid}, 32'h0);
    chk("rst_counts", {16'h0, count0, count1}, 32'h0);
    #6;
    rst_n = 1'b1;
    #1;
    chk("idle_iready", {31'h0, iready}, 32'h1);

    step();
    s = 1'b0; a = 16'h1234; ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    chk("steer_o0", {16'h0, o0}, 32'h1234);
    chk("steer_o0valid", {31'h0, o0valid}, 32'h1);
    chk("steer_o1valid", {31'h0, o1valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", {15'h0, o0valid, o0}, {15'h0, 1'b1, 16'h1234});
    end
    o0ready = 1'b1;
    step();
    o0ready = 1'b0;
    chk("drain_o0valid", {31'h0, o0valid}, 32'h0);
    chk("drain_count0", {24'h0, count0}, 32'h1);

    s = 1'b0; a = 16'h1111; ivalid = 1'b1;
    step();
    a = 16'hBEEF;
    #1;
    chk("bp_iready_s0", {31'h0, iready}, 32'h0);
    step();
    chk("bp_o0_hold", {16'h0, o0}, 32'h1111);
    s = 1'b1;
    #1;
    chk("bp_iready_s1", {31'h0, iready}, 32'h1);
    step();
    ivalid = 1'b0;
    chk("bp_o1", {15'h0, o1valid, o1}, {15'h0, 1'b1, 16'hBEEF});
    o0ready = 1'b1; o1ready = 1'b1;
    step();

    do_reset();
    foreach (tbl[i]) begin
      s = tbl[i].s; a = tbl[i].a; ivalid = tbl[i].iv;
      o0ready = tbl[i].r0; o1ready = tbl[i].r1;
      #1;
      chk($sformatf("vec%0d_iready", i), {31'h0, iready}, {31'h0, tbl[i].er});
      step();
      chk($sformatf("vec%0d_valids", i), {30'h0, o0valid, o1valid}, {30'h0, tbl[i].ev0, tbl[i].ev1});
      chk($sformatf("vec%0d_counts", i), {16'h0, count0, count1}, {16'h0, tbl[i].c0, tbl[i].c1});
    end
    chk("vec_hold_data", {o0, o1}, {16'h5555, 16'h4444});

    do_reset();
    o0ready = 1'b1; o1ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a = 16'(i); s = i[0]; ivalid = 1'b1;
      #1;
      chk("stream_iready", {31'h0, iready}, 32'h1);
      step();
      chk("stream_nobubble", {31'h0, (i[0] ? o1valid : o0valid)}, 32'h1);
    end
    ivalid = 1'b0;
    step();
    chk("stream_counts", {16'h0, count0, count1}, {16'h0, 8'd32, 8'd32});
    chk("stream_queues", q0.size() + q1.size(), 32'h0);

    do_reset();
    o1ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 16'(i * 3); s = 1'b1; ivalid = 1'b1;
      step();
    end
    chk("wrap_255", {24'h0, count1}, 32'd255);
    ivalid = 1'b0;
    step();
    chk("wrap_0", {24'h0, count1}, 32'd0);

    do_reset();
    s = 1'b1; a = 16'hAAAA; ivalid = 1'b1; o1ready = 1'b1;
    step();
    ivalid = 1'b0;
    step();
    a = 16'h5A5A; ivalid = 1'b1; o1ready = 1'b0;
    step();
    ivalid = 1'b0;
    chk("pre_async", {15'h0, o1valid, 8'h0, count1}, {15'h0, 1'b1, 8'h0, 8'd1});
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_o1", {15'h0, o1valid, o1}, 32'h0);
    chk("async_count1", {24'h0, count1}, 32'h0);
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    s = 1'b0; a = 16'hC0DE; ivalid = 1'b1; o0ready = 1'b0;
    step();
    ivalid = 1'b0;
    chk("resume_o0", {15'h0, o0valid, o0}, {15'h0, 1'b1, 16'hC0DE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux2output16bit_stream.md
Name: demux2output16bit_stream

Overview:
- 1-to-2 demultiplexer for the 16-bit datapath. It performs the inverse of the 2-input 16-bit mux: it steers one incoming word to one of two destinations, selected by S.
- Each destination has a one-entry output register with a valid/ready handshake, so a stalled destination never corrupts or duplicates data.
- It sits between a write-back/result source and two consumers, for example the register-file write port and the memory write-data path.
- Per-output delivered-word counters support debug and verification.

Parameters:
- WIDTH, 16, data width of A, O0 and O1.
- CNTW, 8, width of the delivered-word counters COUNT0 and COUNT1.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- S  input  1  destination select: 0 selects output 0, 1 selects output 1
- A  input  WIDTH  input data word
- IVALID  input  1  A and S are valid this cycle
- IREADY  output  1  block accepts A this cycle
- O0  output  WIDTH  output 0 data (registered)
- O0VALID  output  1  O0 holds an undelivered word
- O0READY  input  1  consumer 0 accepts O0
- O1  output  WIDTH  output 1 data (registered)
- O1VALID  output  1  O1 holds an undelivered word
- O1READY  input  1  consumer 1 accepts O1
- COUNT0  output  CNTW  words delivered on output 0
- COUNT1  output  CNTW  words delivered on output 1

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect immediately): O0, O1 = 0; O0VALID, O1VALID = 0; COUNT0, COUNT1 = 0.
  - IREADY is combinational and may be 1 during reset, but no capture occurs while RST_N=0.
- Input handshake:
  - IREADY = (S==0) ? (!O0VALID | O0READY) : (!O1VALID | O1READY). It is combinational from S, the VALID flags and the READY inputs.
  - An input transfer occurs when IVALID & IREADY at a rising edge.
- Capture:
  - On a transfer, A is written into buffer S and OSVALID=1 at that edge. Latency from input to output is 1 cycle.
  - The non-selected buffer, its VALID flag and its data are untouched.
- Output handshake:
  - Output x delivers when OxVALID & OxREADY at an edge.
  - If no capture into x occurs on the same edge: OxVALID clears to 0 and Ox holds its last value.
  - If a capture into x occurs on the same edge: Ox takes the new word and OxVALID stays 1. This gives full throughput of one word per cycle per output.
- Stability: while OxVALID=1 and OxREADY=0, Ox and OxVALID hold constant.
- Head-of-line blocking: if the selected buffer is full and not draining, IREADY=0 and the input stalls. The other output keeps draining independently.
- Only one capture can happen per cycle. Both outputs can deliver in the same cycle.
- Counters:
  - COUNTx increments by 1 on each delivery on output x.
  - Modulo 2^CNTW: 255 wraps to 0 with the default width.
  - A simultaneous capture does not affect the counter.
- Input changes with IVALID=0 are ignored. S is sampled only on a transfer.
- Reset mid-operation: buffered undelivered words are discarded and counters clear. Operation resumes on the first edge after RST_N returns to 1.
- Structure: no state machine beyond the per-output valid flags. The total state is two WIDTH-bit registers, two valid bits and two counters.

Test Plan:
- Reset then idle: hold RST_N=0 for 100 ns, then release with IVALID=0 -> O0=O1=0, both VALIDs 0, COUNT0=COUNT1=0, IREADY=1.
- Single steer: A=16'h1234, S=0, IVALID=1 for one cycle, O0READY=0 -> next cycle O0=16'h1234 and O0VALID=1; O1VALID stays 0; O0 stays stable for 5 stalled cycles; raising O0READY -> O0VALID=0 and COUNT0=1.
- Back-pressure: O0 full with O0READY=0, then present S=0 and A=16'hBEEF -> IREADY=0 and O0 unchanged. Then present S=1 with the same A -> IREADY=1 and O1=16'hBEEF next cycle.
- Streaming: both READYs held at 1; sweep A=0..63 with S alternating 0,1, IVALID=1 every cycle -> each word appears exactly once on the correct output one cycle later, with no bubbles; COUNT0=COUNT1=32.
- Wrap: 256 deliveries on output 1 -> COUNT1 reads 255 then 0.
- Async reset mid-stream: assert RST_N low between clock edges while O1VALID=1 -> O1VALID=0, O1=0 and COUNT1=0 immediately, without waiting for a clock edge.
